// File: rtl/elink_pkg.sv
// Shared types, frame constants and CRC helper for the E-link receive deframer.
// crc8_07 is only referenced when ELINK_RX_CRC_EN is defined.
package elink_pkg;

   localparam logic [7:0] SOP_BYTE      = 8'h3C;
   localparam logic [7:0] EOP_BYTE      = 8'hBC;
   localparam logic [7:0] IDLE_BYTE     = 8'hAA;
   localparam int         PAYLOAD_BYTES = 10;
   localparam int         DATA_W        = 76;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LOCKED,
      ST_PAYLOAD,
`ifdef ELINK_RX_CRC_EN
      ST_CRC,
`endif
      ST_EOP_CHK
   } state_t;

   // CRC-8, polynomial 0x07, one byte folded in MSB-first
   function automatic logic [7:0] crc8_07(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/elink_rx_deframer_byte_align.sv
// Bit-pair window shift register and byte phase counter for the E-link deframer.
// While hunt is high the phase is held at zero so it restarts on the SOP boundary.
module elink_byte_align
   import elink_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       hunt,
   input  logic [1:0] rx,
   output logic       byte_strb,
   output logic [7:0] byte_data
);

   logic [7:0] window;
   logic [1:0] phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window <= '0;
         phase  <= '0;
      end else begin
         window <= {window[5:0], rx};
         phase  <= hunt ? 2'd0 : phase + 2'd1;
      end
   end

   assign byte_data = window;
   assign byte_strb = !hunt && (phase == 2'd3);

endmodule

// File: rtl/elink_rx_deframer.sv
// E-link receive deframer: aligns on SOP, collects a 10-byte frame, publishes 76 bits.
// Optional CRC-8 byte before EOP is enabled by defining ELINK_RX_CRC_EN.
//
// state      | meaning
// ST_HUNT    | search the window for SOP every clk
// ST_LOCKED  | aligned between frames, IDLE or SOP expected
// ST_PAYLOAD | shifting in payload bytes
// ST_CRC     | receiving the CRC byte (ELINK_RX_CRC_EN only)
// ST_EOP_CHK | check EOP (and CRC), then publish or drop
module elink_rx_deframer
   import elink_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        rx_elink2bit,
   output logic [DATA_W-1:0] data_tra_downlink,
   output logic              irq_elink_tra,
   output logic              frame_err,
   output logic              align_err,
   output logic              locked
);

   localparam logic [3:0] LAST_BYTE = 4'(PAYLOAD_BYTES - 1);

   state_t            state, state_nxt;
   logic              byte_strb;
   logic [7:0]        byte_data;
   logic [3:0]        count;
   // Only the low 76 bits of the 80-bit payload are kept; the top nibble falls off the shift.
   logic [DATA_W-1:0] payload;
   logic              frame_ok;
   logic              irq_nxt, ferr_nxt, aerr_nxt;
   logic              clr_frame, shift, load;

   elink_byte_align u_align (
      .clk       (clk),
      .rst       (rst),
      .hunt      (state == ST_HUNT),
      .rx        (rx_elink2bit),
      .byte_strb (byte_strb),
      .byte_data (byte_data)
   );

`ifdef ELINK_RX_CRC_EN
   logic [7:0] crc;
   logic       crc_ok;
   logic       crc_cap;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc    <= '0;
         crc_ok <= 1'b0;
      end else begin
         if (clr_frame)  crc <= '0;
         else if (shift) crc <= crc8_07(crc, byte_data);
         if (crc_cap)    crc_ok <= (byte_data == crc);
      end
   end

   assign frame_ok = (byte_data == EOP_BYTE) && crc_ok;
`else
   assign frame_ok = (byte_data == EOP_BYTE);
`endif

   always_comb begin
      state_nxt = state;
      irq_nxt   = 1'b0;
      ferr_nxt  = 1'b0;
      aerr_nxt  = 1'b0;
      clr_frame = 1'b0;
      shift     = 1'b0;
      load      = 1'b0;
`ifdef ELINK_RX_CRC_EN
      crc_cap   = 1'b0;
`endif
      if (!en) begin
         state_nxt = ST_HUNT;
      end else begin
         case (state)
            ST_HUNT: begin
               if (byte_data == SOP_BYTE) begin
                  state_nxt = ST_PAYLOAD;
                  clr_frame = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (byte_strb) begin
                  if (byte_data == SOP_BYTE) begin
                     state_nxt = ST_PAYLOAD;
                     clr_frame = 1'b1;
                  end else if (byte_data != IDLE_BYTE) begin
                     state_nxt = ST_HUNT;
                     aerr_nxt  = 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (byte_strb) begin
                  shift = 1'b1;
                  if (count == LAST_BYTE) begin
`ifdef ELINK_RX_CRC_EN
                     state_nxt = ST_CRC;
`else
                     state_nxt = ST_EOP_CHK;
`endif
                  end
               end
            end
`ifdef ELINK_RX_CRC_EN
            ST_CRC: begin
               if (byte_strb) begin
                  crc_cap   = 1'b1;
                  state_nxt = ST_EOP_CHK;
               end
            end
`endif
            ST_EOP_CHK: begin
               if (byte_strb) begin
                  if (frame_ok) begin
                     load      = 1'b1;
                     irq_nxt   = 1'b1;
                     state_nxt = ST_LOCKED;
                  end else begin
                     ferr_nxt  = 1'b1;
                     state_nxt = ST_HUNT;
                  end
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= ST_HUNT;
         count             <= '0;
         payload           <= '0;
         data_tra_downlink <= '0;
         irq_elink_tra     <= 1'b0;
         frame_err         <= 1'b0;
         align_err         <= 1'b0;
         locked            <= 1'b0;
      end else begin
         state         <= state_nxt;
         irq_elink_tra <= irq_nxt;
         frame_err     <= ferr_nxt;
         align_err     <= aerr_nxt;
         locked        <= (state_nxt != ST_HUNT);
         if (clr_frame)  count <= '0;
         else if (shift) count <= count + 4'd1;
         if (shift)      payload <= {payload[DATA_W-9:0], byte_data};
         if (load)       data_tra_downlink <= payload;
      end
   end

endmodule

// File: tb/tb_elink_rx_deframer.sv
// Randomised bench for elink_rx_deframer against a byte-level frame parser model.
// Build with ELINK_RX_CRC_EN defined to exercise the CRC frame format.
module tb_elink_rx_deframer;

   localparam logic [7:0] SOP  = 8'h3C;
   localparam logic [7:0] EOP  = 8'hBC;
   localparam logic [7:0] IDLE = 8'hAA;
`ifdef ELINK_RX_CRC_EN
   localparam int FB = 13;
`else
   localparam int FB = 12;
`endif
   localparam logic [79:0] PL_A = 80'h0123456789ABCDEF0123;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [1:0]  rx  = 2'b00;
   logic [75:0] data_tra_downlink;
   logic        irq_elink_tra, frame_err, align_err, locked;

   elink_rx_deframer dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .rx_elink2bit      (rx),
      .data_tra_downlink (data_tra_downlink),
      .irq_elink_tra     (irq_elink_tra),
      .frame_err         (frame_err),
      .align_err         (align_err),
      .locked            (locked)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // stimulus: one bit-pair and one enable value per clock edge
   logic [1:0] pr[$];
   bit         enq[$];

   // model expectations per edge
   bit        e_irq[], e_ferr[], e_aerr[], e_lock[];
   bit [75:0] e_data[];

   int dut_irq[$];
   int n_ferr, n_aerr;

   function automatic logic [1:0] pair_at(int i);
      return (i < 0 || i >= pr.size()) ? 2'b00 : pr[i];
   endfunction

   function automatic logic [7:0] win(int p);
      return {pair_at(p-3), pair_at(p-2), pair_at(p-1), pair_at(p)};
   endfunction

   function automatic bit en_at(int e);
      return (e < enq.size()) ? enq[e] : 1'b1;
   endfunction

   function automatic logic [7:0] crc_ref(input logic [79:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 79; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      for (int k = 3; k >= 0; k--) begin
         pr.push_back(b[2*k+1 -: 2]);
         enq.push_back(1'b1);
      end
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) push_byte(IDLE);
   endtask

   task automatic push_frame(input logic [79:0] pl, input logic [7:0] eop, input logic [7:0] crc_x);
      logic [7:0] c;
      c = crc_ref(pl) ^ crc_x;
      push_byte(SOP);
      for (int j = 0; j < 10; j++) push_byte(pl[79-8*j -: 8]);
`ifdef ELINK_RX_CRC_EN
      push_byte(c);
`endif
      push_byte(eop);
   endtask

   task automatic set_lock(input int a, input int b);
      for (int e = a; e <= b; e++) if (e >= 0 && e < e_lock.size()) e_lock[e] = 1'b1;
   endtask

   // Byte-level parse of the pair stream: hunt for SOP at any pair offset, then
   // read whole bytes every 4 pairs; each decision lands on the edge after its last pair.
   task automatic compute();
      int          n, mode, p, s, q, f, ev, a, nb;
      bit          ok;
      logic [79:0] pl;
      logic [7:0]  b;
      bit          upd[];
      bit [75:0]   updv[];
      bit [75:0]   cur;
      n = pr.size();
      e_irq = new[n]; e_ferr = new[n]; e_aerr = new[n]; e_lock = new[n];
      e_data = new[n]; upd = new[n]; updv = new[n];
      mode = 0; p = 0; s = 0; q = 0;
      while (1) begin
         if (mode == 0) begin
            f = -1;
            for (int x = p; x + 1 < n; x++) begin
               if (en_at(x+1) && win(x) == SOP) begin f = x; break; end
            end
            if (f < 0) break;
            s = f + 1; set_lock(s, s); q = f + 4; mode = 1;
         end else begin
            nb = (mode == 1) ? FB - 1 : 1;
            ev = q + 4*(nb-1) + 1;
            a  = -1;
            for (int e = s + 1; e <= ev && e < n; e++) begin
               if (!en_at(e)) begin a = e; break; end
            end
            if (a >= 0) begin
               set_lock(s, a-1); p = a; mode = 0;
            end else if (ev >= n) begin
               set_lock(s, n-1); break;
            end else if (mode == 1) begin
               for (int j = 0; j < 10; j++) pl[79-8*j -: 8] = win(q + 4*j);
               ok = (win(ev-1) == EOP);
`ifdef ELINK_RX_CRC_EN
               ok = ok && (win(q + 40) == crc_ref(pl));
`endif
               if (ok) begin
                  e_irq[ev] = 1'b1; upd[ev] = 1'b1; updv[ev] = pl[75:0];
                  set_lock(s, ev); s = ev; q = ev + 3; mode = 2;
               end else begin
                  e_ferr[ev] = 1'b1; set_lock(s, ev-1); p = ev; mode = 0;
               end
            end else begin
               b = win(q);
               if (b == SOP || b == IDLE) begin
                  set_lock(s, ev); s = ev; q = ev + 3; mode = (b == SOP) ? 1 : 2;
               end else begin
                  e_aerr[ev] = 1'b1; set_lock(s, ev-1); p = ev; mode = 0;
               end
            end
         end
      end
      cur = '0;
      for (int e = 0; e < n; e++) begin
         if (upd[e]) cur = updv[e];
         e_data[e] = cur;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data"},  data_tra_downlink, 76'h0);
      chk({tag, "_irq"},   76'(irq_elink_tra), 76'h0);
      chk({tag, "_ferr"},  76'(frame_err),     76'h0);
      chk({tag, "_aerr"},  76'(align_err),     76'h0);
      chk({tag, "_lock"},  76'(locked),        76'h0);
   endtask

   // rst_at >= 0: assert reset asynchronously between edges at that index and stop
   task automatic run_stream(input int rst_at);
      int n;
      compute();
      n = pr.size();
      dut_irq.delete(); n_ferr = 0; n_aerr = 0;
      rst = 1'b0; en = 1'b0; rx = 2'b00;
      @(negedge clk); @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         rx = pr[i];
         en = enq[i];
         if (i == rst_at) begin
            #2 rst = 1'b0;
            #1 check_zero("async_rst");
            break;
         end
         @(negedge clk);
         chk($sformatf("irq@%0d", i),  76'(irq_elink_tra), 76'(e_irq[i]));
         chk($sformatf("ferr@%0d", i), 76'(frame_err),     76'(e_ferr[i]));
         chk($sformatf("aerr@%0d", i), 76'(align_err),     76'(e_aerr[i]));
         chk($sformatf("lock@%0d", i), 76'(locked),        76'(e_lock[i]));
         chk($sformatf("data@%0d", i), data_tra_downlink,  e_data[i]);
         if (irq_elink_tra) dut_irq.push_back(i);
         if (frame_err) n_ferr++;
         if (align_err) n_aerr++;
      end
      pr.delete();
      enq.delete();
   endtask

   function automatic logic [79:0] rnd_pl();
      return {16'($urandom()), $urandom(), $urandom()};
   endfunction

   initial begin
      int          s;
      logic [79:0] pl_b;

      // idle only, then the reference frame
      push_idle(8);
      push_frame(PL_A, EOP, 8'h00);
      push_idle(3);
      run_stream(-1);
      chk("basic_irqs", 76'(dut_irq.size()), 76'd1);
      chk("basic_data", data_tra_downlink, 76'h123456789ABCDEF0123);

      // SOP at each bit-pair phase
      for (int off = 0; off < 4; off++) begin
         push_idle(2);
         for (int k = 0; k < off; k++) begin pr.push_back(2'b10); enq.push_back(1'b1); end
         push_frame(PL_A, EOP, 8'h00);
         push_idle(2);
         run_stream(-1);
         chk($sformatf("phase%0d_irqs", off), 76'(dut_irq.size()), 76'd1);
         chk($sformatf("phase%0d_data", off), data_tra_downlink, 76'h123456789ABCDEF0123);
      end

      // bad EOP is dropped, data held, lock lost
      pl_b = rnd_pl();
      push_idle(2);
      push_frame(PL_A, EOP, 8'h00);
      push_idle(2);
      push_frame(pl_b, 8'hBD, 8'h00);
      push_idle(3);
      run_stream(-1);
      chk("badeop_irqs", 76'(dut_irq.size()), 76'd1);
      chk("badeop_ferr", 76'(n_ferr), 76'd1);
      chk("badeop_data", data_tra_downlink, PL_A[75:0]);
      chk("badeop_lock", 76'(locked), 76'd0);

      // unexpected byte while locked, then relock
      pl_b = rnd_pl();
      push_idle(2);
      push_frame(PL_A, EOP, 8'h00);
      push_byte(8'h55);
      push_idle(2);
      push_frame(pl_b, EOP, 8'h00);
      push_idle(2);
      run_stream(-1);
      chk("align_aerr", 76'(n_aerr), 76'd1);
      chk("align_irqs", 76'(dut_irq.size()), 76'd2);
      chk("align_data", data_tra_downlink, pl_b[75:0]);

      // enable dropped during payload byte 5, frame resent
      push_idle(2);
      s = pr.size();
      push_frame(PL_A, EOP, 8'h00);
      for (int k = 0; k < 4; k++) enq[s + 4*6 + k] = 1'b0;
      push_idle(2);
      push_frame(PL_A, EOP, 8'h00);
      push_idle(2);
      run_stream(-1);
      chk("endrop_irqs", 76'(dut_irq.size()), 76'd1);
      chk("endrop_ferr", 76'(n_ferr), 76'd0);

      // async reset in the middle of a second frame
      push_idle(2);
      push_frame(PL_A, EOP, 8'h00);
      s = pr.size();
      push_frame(rnd_pl(), EOP, 8'h00);
      run_stream(s + 20);

`ifdef ELINK_RX_CRC_EN
      // corrupted CRC with a correct EOP
      push_idle(2);
      push_frame(PL_A, EOP, 8'h00);
      push_idle(1);
      push_frame(rnd_pl(), EOP, 8'h01);
      push_idle(2);
      run_stream(-1);
      chk("crc_irqs", 76'(dut_irq.size()), 76'd1);
      chk("crc_ferr", 76'(n_ferr), 76'd1);
      chk("crc_data", data_tra_downlink, PL_A[75:0]);
`endif

      // back-to-back frames, no IDLE
      push_idle(2);
      for (int k = 0; k < 3; k++) push_frame(rnd_pl(), EOP, 8'h00);
      push_idle(2);
      run_stream(-1);
      chk("b2b_irqs", 76'(dut_irq.size()), 76'd3);
      if (dut_irq.size() == 3) begin
         chk("b2b_gap0", 76'(dut_irq[1] - dut_irq[0]), 76'(FB*4));
         chk("b2b_gap1", 76'(dut_irq[2] - dut_irq[1]), 76'(FB*4));
      end

      // random mix: gaps, slips, junk, corrupt frames, enable glitches
      for (int r = 0; r < 4; r++) begin
         push_idle(1);
         for (int f = 0; f < 8; f++) begin
            push_idle($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) push_byte(8'($urandom()));
            if ($urandom_range(0, 5) == 0) begin pr.push_back(2'b10); enq.push_back(1'b1); end
            s = pr.size();
            push_frame(rnd_pl(), ($urandom_range(0, 4) == 0) ? 8'($urandom()) : EOP,
                       ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            if ($urandom_range(0, 6) == 0) enq[s + $urandom_range(0, FB*4 - 1)] = 1'b0;
         end
         push_idle(2);
         run_stream(-1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/elink_rx_deframer.md
# elink_rx_deframer

Receive-side E-link framer between the 2-bit E-link downlink lane and the MOPSHUB core transmit path. It shifts in the serial 2-bit stream and finds byte alignment on a start-of-packet byte. It assembles each frame into the 76-bit downlink word and signals the core with a one-cycle interrupt. Malformed frames are dropped and flagged; the deframer never emits partial data.

## Interface
- `SOP_BYTE`, 8'h3C, start-of-packet marker
- `EOP_BYTE`, 8'hBC, end-of-packet marker
- `IDLE_BYTE`, 8'hAA, inter-frame fill
- `PAYLOAD_BYTES`, 10, payload length in bytes (80 bits)
- `clk`  in  1  system clock (40 MHz E-link domain)
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  deframer enable; low forces HUNT
- `rx_elink2bit`  in  2  serial lane; bit [1] is the earlier bit, MSB-first
- `data_tra_downlink`  out  76  last good frame payload, held until the next good frame
- `irq_elink_tra`  out  1  one-cycle pulse: `data_tra_downlink` updated
- `frame_err`  out  1  one-cycle pulse: bad EOP or bad CRC, frame dropped
- `align_err`  out  1  one-cycle pulse: lock lost (unexpected inter-frame byte)
- `locked`  out  1  level: byte alignment established

## Operation
- 8-bit window shift register; every clk: `window <= {window[5:0], rx_elink2bit}`. A byte completes every 4 clks once locked, with a 2-bit phase counter.
- States: HUNT, LOCKED, PAYLOAD, CRC (only with macro), EOP_CHK.
- HUNT: compare the window every clk. If `window == SOP_BYTE`, clear phase, clear byte count, go to PAYLOAD, and set `locked`=1.
- LOCKED: at each byte boundary:
  - SOP goes to PAYLOAD.
  - IDLE stays in LOCKED.
  - Any other byte pulses `align_err`, clears `locked`, and goes to HUNT.
- PAYLOAD: shift each byte into an 80-bit payload register. After `PAYLOAD_BYTES` bytes, go to CRC or EOP_CHK.
- EOP_CHK: check the byte at the boundary.
  - Byte == EOP and CRC ok: load `data_tra_downlink <= payload[75:0]` (payload[79:76] ignored), pulse `irq_elink_tra`, go to LOCKED.
  - Otherwise: pulse `frame_err`, clear `locked`, go to HUNT.
- `en` low in any state: go to HUNT next clk, clear `locked`, drop the partial frame, no pulses. `data_tra_downlink` is kept.
- The SOP pattern inside a payload has no meaning. Count only.

## Timing
- Reset values: `data_tra_downlink`=76'h0; `irq_elink_tra`, `frame_err`, `align_err`, `locked` all 0; state HUNT; window, phase and count all 0.
- Reset asserted mid-frame clears everything immediately and asynchronously. No pulse is emitted on reset release.
- SOP detect: `locked` rises the clk after the last SOP bit-pair is sampled.
- Frame without CRC: 12 bytes = 48 clks SOP-to-EOP.
- Latency: `irq_elink_tra` and the new data are both registered outputs, asserted in the clk after the final EOP bit-pair is sampled.
- Data changes in the same cycle as the irq. Output pulses are exactly 1 clk wide.
- At most one of `irq_elink_tra`, `frame_err`, `align_err` is high in any cycle.
- Back-to-back frames: an SOP directly after an EOP (no IDLE) is legal.
- Minimum frame period is 48 clks, or 52 clks with CRC.
- No consumer back-pressure: the core must sample within 48 clks.

## Configuration
- `ELINK_RX_CRC_EN` defined:
  - One CRC-8 byte follows the payload, before EOP.
  - Polynomial 0x07, init 0x00, MSB-first over the 10 payload bytes.
  - A mismatch at EOP_CHK gives `frame_err` and no irq, even if EOP is correct.
  - Frame is 13 bytes.
- Undefined: CRC state and logic are absent; the frame is 12 bytes.

## Structure
- Package `elink_pkg`:
  - state enum typedef;
  - SOP/EOP/IDLE default constants;
  - `crc8_07` byte function (used only under the macro).
- Sub-module `elink_byte_align`: window shift register, phase counter and byte-strobe generation. It has a `hunt` input and outputs `byte_strb` plus `byte_data`.
- The top holds the FSM, payload register and outputs.

## Test plan
- Reset, then IDLE bytes only: `locked`=0 and no pulses. Then SOP + payload 80'h0_123456789ABCDEF0123 + EOP: `irq_elink_tra` pulses once and `data_tra_downlink`=76'h123456789ABCDEF0123.
- SOP injected at each of the 4 bit-pair phases: locks every time; payload decoded identically.
- EOP replaced by 8'hBD: `frame_err` pulse, no irq, data unchanged, HUNT, `locked`=0.
- After a good frame, send byte 8'h55 in LOCKED: `align_err` pulse. The next SOP relocks.
- `en` dropped at payload byte 5, raised, full frame resent: no pulse for the aborted frame, one irq for the resent one. Async `rst` mid-frame: all outputs return to 0.
- `ELINK_RX_CRC_EN`: correct CRC gives irq; CRC XOR 8'h01 gives `frame_err`. Back-to-back frames with no IDLE give two irqs exactly 52 clks apart.
